// File: rtl/sprite_compositor.sv
// Three-stage pixel compositor: scrolling background window plus NUM_SPR keyed sprites.
// Define SPRITE_COLLISION_EN to build the sticky sprite-overlap detector.
module sprite_compositor #(
  parameter int unsigned WIDTH     = 10,
  parameter int unsigned NUM_SPR   = 4,
  parameter int unsigned SPR_W     = 14,
  parameter int unsigned SPR_H     = 16,
  parameter int unsigned SPR_AW    = 8,
  parameter int unsigned BG_W      = 160,
  parameter int unsigned BG_H      = 240,
  parameter int unsigned BG_AW     = 16,
  parameter int unsigned BG_X      = 200,
  parameter int unsigned BG_Y      = 150,
  parameter logic [11:0] KEY       = 12'hA0A,
  parameter int unsigned FRAME_DIV = 5,
  parameter int unsigned H_LAST    = 799,
  parameter int unsigned V_LAST    = 479,
  localparam int unsigned SW       = $clog2(BG_H)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          i_hor_pix,
  input  logic [WIDTH-1:0]          i_ver_pix,
  input  logic [NUM_SPR*WIDTH-1:0]  i_spr_x,
  input  logic [NUM_SPR*WIDTH-1:0]  i_spr_y,
  input  logic [NUM_SPR-1:0]        i_spr_en,
  output logic [NUM_SPR*SPR_AW-1:0] o_spr_addr,
  input  logic [NUM_SPR*12-1:0]     i_spr_data,
  output logic [BG_AW-1:0]          o_bg_addr,
  input  logic [11:0]               i_bg_data,
  input  logic                      i_scroll_en,
  output logic [11:0]               o_pixel_rgb,
  output logic [SW-1:0]             o_scroll_pos,
  output logic                      o_scroll_tick,
  output logic                      o_collision,
  input  logic                      i_collision_clr
);

  localparam int unsigned FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [WIDTH:0] SprW = (WIDTH+1)'(SPR_W);
  localparam logic [WIDTH:0] SprH = (WIDTH+1)'(SPR_H);
  localparam logic [WIDTH:0] BgX0 = (WIDTH+1)'(BG_X);
  localparam logic [WIDTH:0] BgX1 = (WIDTH+1)'(BG_X + BG_W);
  localparam logic [WIDTH:0] BgY0 = (WIDTH+1)'(BG_Y);
  localparam logic [WIDTH:0] BgY1 = (WIDTH+1)'(BG_Y + BG_H);

  logic [NUM_SPR-1:0]        r_hit_a, r_hit_b;
  logic                      r_bg_on_a, r_bg_on_b;
  logic                      r_vld_a, r_vld_b;
  logic [NUM_SPR*SPR_AW-1:0] r_spr_addr;
  logic [BG_AW-1:0]          r_bg_addr;
  logic [11:0]               r_pixel;
  logic [SW-1:0]             r_scroll_pos;
  logic [FW-1:0]             r_frame_cnt;
  logic                      r_tick;
  logic                      r_eof;
  logic                      r_coll;

  // Extra top bit keeps sprite bounds from wrapping near 2^WIDTH.
  logic [WIDTH:0]    w_h, w_v;
  logic [NUM_SPR-1:0] w_hit;
  logic [SPR_AW-1:0] w_spr_addr [NUM_SPR];

  assign w_h = {1'b0, i_hor_pix};
  assign w_v = {1'b0, i_ver_pix};

  for (genvar g = 0; g < NUM_SPR; g++) begin : g_spr
    logic [WIDTH:0]   w_x, w_y;
    logic [WIDTH-1:0] w_dx, w_dy;
    logic [31:0]      w_lin;
    assign w_x      = {1'b0, i_spr_x[g*WIDTH +: WIDTH]};
    assign w_y      = {1'b0, i_spr_y[g*WIDTH +: WIDTH]};
    assign w_hit[g] = i_spr_en[g] && (w_h >= w_x) && (w_h < w_x + SprW) &&
                      (w_v >= w_y) && (w_v < w_y + SprH);
    assign w_dx     = i_hor_pix - i_spr_x[g*WIDTH +: WIDTH];
    assign w_dy     = i_ver_pix - i_spr_y[g*WIDTH +: WIDTH];
    assign w_lin    = 32'(w_dx) + 32'(w_dy) * SPR_W;
    assign w_spr_addr[g] = SPR_AW'(w_lin);
  end

  logic             w_bg_on;
  logic [WIDTH-1:0] w_r, w_pos, w_row;
  logic [31:0]      w_bg_lin;

  assign w_bg_on  = (w_h >= BgX0) && (w_h < BgX1) && (w_v >= BgY0) && (w_v < BgY1);
  assign w_r      = i_ver_pix - WIDTH'(BG_Y);
  assign w_pos    = WIDTH'(r_scroll_pos);
  // Wrap the scrolled row back into [0, BG_H) without a modulo.
  assign w_row    = (w_r >= w_pos) ? (w_r - w_pos) : (w_r + WIDTH'(BG_H) - w_pos);
  assign w_bg_lin = 32'(i_hor_pix - WIDTH'(BG_X)) + 32'(w_row) * BG_W;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_a    <= '0;
      r_bg_on_a  <= 1'b0;
      r_vld_a    <= 1'b0;
      r_spr_addr <= '0;
      r_bg_addr  <= '0;
      r_hit_b    <= '0;
      r_bg_on_b  <= 1'b0;
      r_vld_b    <= 1'b0;
    end else begin
      r_vld_a   <= 1'b1;
      r_hit_a   <= w_hit;
      r_bg_on_a <= w_bg_on;
      if (w_bg_on) r_bg_addr <= BG_AW'(w_bg_lin);
      for (int i = 0; i < NUM_SPR; i++) begin
        if (w_hit[i]) r_spr_addr[i*SPR_AW +: SPR_AW] <= w_spr_addr[i];
      end
      r_hit_b   <= r_hit_a;
      r_bg_on_b <= r_bg_on_a;
      r_vld_b   <= r_vld_a;
    end
  end

  logic [NUM_SPR-1:0] w_opaque;
  logic [11:0]        w_rgb;

  always_comb begin
    w_opaque = '0;
    w_rgb    = (r_vld_b && r_bg_on_b) ? i_bg_data : 12'h000;
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      w_opaque[i] = r_vld_b && r_hit_b[i] && (i_spr_data[i*12 +: 12] != KEY);
      if (w_opaque[i]) w_rgb = i_spr_data[i*12 +: 12];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pixel <= 12'h000;
    else        r_pixel <= w_rgb;
  end

`ifdef SPRITE_COLLISION_EN
  logic w_any, w_multi;

  always_comb begin
    w_any   = 1'b0;
    w_multi = 1'b0;
    for (int i = 0; i < NUM_SPR; i++) begin
      if (w_opaque[i]) begin
        if (w_any) w_multi = 1'b1;
        w_any = 1'b1;
      end
    end
  end

  // A new overlap in the same clk as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               r_coll <= 1'b0;
    else if (w_multi)         r_coll <= 1'b1;
    else if (i_collision_clr) r_coll <= 1'b0;
  end
`else
  logic w_unused_clr;
  assign w_unused_clr = i_collision_clr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_coll <= 1'b0;
    else        r_coll <= 1'b0;
  end
`endif

  logic w_eof, w_frame_end;
  assign w_eof       = (i_hor_pix == WIDTH'(H_LAST)) && (i_ver_pix == WIDTH'(V_LAST));
  assign w_frame_end = w_eof && !r_eof;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_eof        <= 1'b0;
      r_frame_cnt  <= '0;
      r_scroll_pos <= '0;
      r_tick       <= 1'b0;
    end else begin
      r_eof  <= w_eof;
      r_tick <= 1'b0;
      if (w_frame_end && i_scroll_en) begin
        if (r_frame_cnt == FW'(FRAME_DIV - 1)) begin
          r_frame_cnt  <= '0;
          r_tick       <= 1'b1;
          r_scroll_pos <= (r_scroll_pos == SW'(BG_H - 1)) ? '0 : r_scroll_pos + 1'b1;
        end else begin
          r_frame_cnt <= r_frame_cnt + 1'b1;
        end
      end
    end
  end

  assign o_spr_addr    = r_spr_addr;
  assign o_bg_addr     = r_bg_addr;
  assign o_pixel_rgb   = r_pixel;
  assign o_scroll_pos  = r_scroll_pos;
  assign o_scroll_tick = r_tick;
  assign o_collision   = r_coll;

endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: vector table through a latency-3 scoreboard plus
// hand sequences for scrolling, freeze, collision and reset.
module tb_sprite_compositor;
  localparam int WIDTH   = 10;
  localparam int NUM_SPR = 4;
  localparam int SPR_AW  = 8;
  localparam int BG_AW   = 16;
  localparam int SW      = 8;
  localparam logic [11:0] KEY = 12'hA0A;
`ifdef SPRITE_COLLISION_EN
  localparam logic CollEn = 1'b1;
`else
  localparam logic CollEn = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [WIDTH-1:0]          hor, ver;
  logic [NUM_SPR*WIDTH-1:0]  spr_x, spr_y;
  logic [NUM_SPR-1:0]        spr_en;
  logic [NUM_SPR*SPR_AW-1:0] spr_addr;
  logic [NUM_SPR*12-1:0]     spr_data;
  logic [BG_AW-1:0]          bg_addr;
  logic [11:0]               bg_data;
  logic                      scroll_en;
  logic [11:0]               rgb;
  logic [SW-1:0]             pos;
  logic                      tick;
  logic                      coll;
  logic                      coll_clr;

  sprite_compositor dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_hor_pix      (hor),
    .i_ver_pix      (ver),
    .i_spr_x        (spr_x),
    .i_spr_y        (spr_y),
    .i_spr_en       (spr_en),
    .o_spr_addr     (spr_addr),
    .i_spr_data     (spr_data),
    .o_bg_addr      (bg_addr),
    .i_bg_data      (bg_data),
    .i_scroll_en    (scroll_en),
    .o_pixel_rgb    (rgb),
    .o_scroll_pos   (pos),
    .o_scroll_tick  (tick),
    .o_collision    (coll),
    .i_collision_clr(coll_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] bgf(input logic [BG_AW-1:0] a);
    return a[11:0] ^ {8'h35, a[15:12]};
  endfunction

  // Synchronous ROM models with one clk of read latency.
  logic [11:0] rom [NUM_SPR][256];
  always @(posedge clk) begin
    for (int i = 0; i < NUM_SPR; i++) spr_data[i*12 +: 12] <= rom[i][spr_addr[i*SPR_AW +: SPR_AW]];
    bg_data <= bgf(bg_addr);
  end

  typedef struct {int h; int v; logic [11:0] rgb;} vec_t;
  typedef struct {int due; logic [11:0] rgb; int tag;} sb_t;
  vec_t tv[$];
  sb_t  sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_ticks = 0;
  int   m_fc = 0;
  int   m_pos = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic step();
    sb_t e;
    @(negedge clk);
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk($sformatf("pixel_rgb vec %0d", e.tag), 32'(rgb), 32'(e.rgb));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int h, input int v, input logic [11:0] exp, input int tag);
    hor = WIDTH'(h);
    ver = WIDTH'(v);
    sb.push_back('{due: cyc + 3, rgb: exp, tag: tag});
    step();
  endtask

  task automatic drain();
    for (int k = 0; k < 8 && sb.size() > 0; k++) step();
    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic frame(input int hold);
    logic exp_tick;
    exp_tick = scroll_en && (m_fc == 4);
    if (scroll_en) begin
      if (m_fc == 4) begin
        m_fc  = 0;
        m_pos = (m_pos == 239) ? 0 : m_pos + 1;
      end else begin
        m_fc++;
      end
    end
    hor = 10'd799;
    ver = 10'd479;
    step();
    chk("scroll_tick after frame_end", 32'(tick), 32'(exp_tick));
    if (tick) n_ticks++;
    for (int k = 1; k < hold; k++) begin
      step();
      chk("scroll_tick single pulse", 32'(tick), 32'd0);
    end
    hor = '0;
    ver = '0;
    step();
    chk("scroll_tick gap", 32'(tick), 32'd0);
    chk("scroll_pos", 32'(pos), 32'(m_pos));
  endtask

  task automatic check_zero(input string when);
    chk({when, " pixel_rgb"}, 32'(rgb), 32'd0);
    chk({when, " spr_addr"}, 32'(spr_addr), 32'd0);
    chk({when, " bg_addr"}, 32'(bg_addr), 32'd0);
    chk({when, " scroll_pos"}, 32'(pos), 32'd0);
    chk({when, " scroll_tick"}, 32'(tick), 32'd0);
    chk({when, " collision"}, 32'(coll), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    logic did10;
    rst_n = 1'b0;
    hor = '0;
    ver = '0;
    scroll_en = 1'b0;
    coll_clr = 1'b0;
    spr_en = 4'hF;
    spr_x = {10'd1020, 10'd600, 10'd276, 10'd270};
    spr_y = {10'd0, 10'd400, 10'd300, 10'd300};
    for (int a = 0; a < 256; a++) begin
      rom[0][a] = 12'hF00;
      rom[1][a] = 12'h00F;
      rom[2][a] = 12'h0F0;
      rom[3][a] = 12'hFF0;
    end
    rom[0][0] = KEY;

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    tv.push_back('{278, 305, 12'hF00});
    tv.push_back('{270, 300, bgf(16'd24070)});
    tv.push_back('{271, 300, 12'hF00});
    tv.push_back('{276, 300, 12'hF00});
    tv.push_back('{283, 300, 12'hF00});
    tv.push_back('{284, 300, 12'h00F});
    tv.push_back('{290, 300, bgf(16'd24090)});
    tv.push_back('{289, 315, 12'h00F});
    tv.push_back('{289, 316, bgf(16'd26649)});
    tv.push_back('{199, 200, 12'h000});
    tv.push_back('{200, 150, bgf(16'd0)});
    tv.push_back('{359, 389, bgf(16'd38399)});
    tv.push_back('{360, 389, 12'h000});
    tv.push_back('{200, 390, 12'h000});
    tv.push_back('{600, 400, 12'h0F0});
    tv.push_back('{1021, 5, 12'hFF0});
    tv.push_back('{1023, 15, 12'hFF0});
    tv.push_back('{1023, 16, 12'h000});
    for (int h = 0; h < 10; h++) tv.push_back('{h, 5, 12'h000});
    for (int i = 0; i < tv.size(); i++) drive(tv[i].h, tv[i].v, tv[i].rgb, i);
    drain();

    drive(278, 305, 12'hF00, 100);
    chk("spr_addr[0] at (278,305)", 32'(spr_addr[7:0]), 32'd78);
    chk("spr_addr[1] at (278,305)", 32'(spr_addr[15:8]), 32'd72);
    chk("bg_addr at (278,305)", 32'(bg_addr), 32'd24878);
    drive(290, 300, bgf(16'd24090), 101);
    chk("spr_addr[0] holds on miss", 32'(spr_addr[7:0]), 32'd78);
    chk("spr_addr[1] at (290,300) miss holds", 32'(spr_addr[15:8]), 32'd72);
    drain();

    hor = 10'd600;
    ver = 10'd400;
    coll_clr = 1'b1;
    repeat (4) step();
    coll_clr = 1'b0;
    chk("collision cleared", 32'(coll), 32'd0);
    hor = 10'd278;
    ver = 10'd305;
    step();
    hor = 10'd600;
    ver = 10'd400;
    step();
    step();
    chk("collision rises", 32'(coll), 32'(CollEn));
    repeat (3) step();
    chk("collision sticky", 32'(coll), 32'(CollEn));
    coll_clr = 1'b1;
    step();
    coll_clr = 1'b0;
    chk("collision clear next clk", 32'(coll), 32'd0);
    hor = 10'd278;
    ver = 10'd305;
    step();
    hor = 10'd600;
    ver = 10'd400;
    step();
    coll_clr = 1'b1;
    step();
    coll_clr = 1'b0;
    chk("collision set wins over clear", 32'(coll), 32'(CollEn));
    coll_clr = 1'b1;
    step();
    coll_clr = 1'b0;

    scroll_en = 1'b1;
    did10 = 1'b0;
    for (int f = 0; f < 1200; f++) begin
      frame((f % 7 == 3) ? 2 : 1);
      if (m_pos == 10 && !did10) begin
        did10 = 1'b1;
        drive(200, 150, bgf(16'd36800), 200);
        chk("bg_addr at scroll 10", 32'(bg_addr), 32'd36800);
        drain();
      end
      if (f == 1198) chk("scroll_pos before wrap", 32'(pos), 32'd239);
    end
    chk("scroll_pos wrapped", 32'(pos), 32'd0);
    chk("tick count over full wrap", 32'(n_ticks), 32'd240);

    frame(1);
    frame(1);
    scroll_en = 1'b0;
    t0 = n_ticks;
    for (int f = 0; f < 20; f++) frame(1);
    chk("freeze scroll_pos", 32'(pos), 32'd0);
    chk("freeze no ticks", 32'(n_ticks - t0), 32'd0);
    scroll_en = 1'b1;
    for (int f = 0; f < 3; f++) frame(1);
    chk("frame count held across freeze", 32'(pos), 32'd1);

    hor = 10'd278;
    ver = 10'd305;
    step();
    step();
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("mid-line reset");
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_fc = 0;
    m_pos = 0;
    step();
    chk("black 1 clk after release", 32'(rgb), 32'd0);
    step();
    chk("black 2 clk after release", 32'(rgb), 32'd0);
    step();
    chk("pixel 3 clk after release", 32'(rgb), 32'hF00);
    chk("scroll_pos restart", 32'(pos), 32'd0);
    for (int f = 0; f < 5; f++) frame(1);
    chk("first scroll step after reset", 32'(pos), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sprite_compositor.md
# sprite_compositor

Parametrised pixel compositor for the VGA racing display. It draws a vertically scrolling background window and up to NUM_SPR fixed-size sprites, each with its own position, enable and colour ROM. It applies a transparency key and a fixed sprite priority, and flags sprite-to-sprite overlap as a collision. It sits between the VGA driver's pixel counters and the driver's colour inputs, and replaces the single-car, single-background mux.

## Interface
- WIDTH, 10: pixel coordinate width.
- NUM_SPR, 4: sprite channels (1..8); index 0 has the highest priority.
- SPR_W, 14 / SPR_H, 16: sprite size in pixels.
- SPR_AW, 8: sprite ROM address width; SPR_W*SPR_H must be ≤ 2^SPR_AW.
- BG_W, 160 / BG_H, 240: background image size.
- BG_AW, 16: background ROM address width.
- BG_X, 200 / BG_Y, 150: screen offset of the background window.
- KEY, 12'hA0A: transparent colour for sprites.
- FRAME_DIV, 5: frames per scroll step (≥1).
- H_LAST, 799 / V_LAST, 479: coordinate pair that marks end of frame.
- clk  in  1  system clock (100 MHz).
- rst_n  in  1  asynchronous active-low reset.
- hor_pix, ver_pix  in  WIDTH each  current pixel coordinates.
- spr_x, spr_y  in  NUM_SPR*WIDTH each  sprite top-left positions; channel i occupies bits [i*WIDTH +: WIDTH].
- spr_en  in  NUM_SPR  per-sprite enable.
- spr_addr  out  NUM_SPR*SPR_AW  sprite ROM addresses.
- spr_data  in  NUM_SPR*12  sprite ROM data, returned 1 clk after the address.
- bg_addr  out  BG_AW  background ROM address.
- bg_data  in  12  background ROM data, returned 1 clk after the address.
- scroll_en  in  1  allows scrolling; 0 freezes the scroll position.
- pixel_rgb  out  12  composited colour.
- scroll_pos  out  log2(BG_H) bits  current scroll offset.
- scroll_tick  out  1  one-clk pulse on each scroll step.
- collision  out  1  sticky sprite-overlap flag.
- collision_clr  in  1  synchronous clear of `collision`.

## Operation
- **Stage A (registered).**
  - A sprite hits when `spr_en[i] && hor ≥ x && hor < x+SPR_W && ver ≥ y && ver < y+SPR_H`.
  - Bounds are computed in WIDTH+1 bits, so a sprite near 2^WIDTH does not wrap.
  - `spr_addr[i] = (hor-x) + (ver-y)*SPR_W`. The address holds its last value when the sprite misses.
  - `bg_on` is set when the pixel lies inside [BG_X, BG_X+BG_W) × [BG_Y, BG_Y+BG_H).
  - Background row: `r = ver-BG_Y`; `row = r ≥ scroll_pos ? r-scroll_pos : r+BG_H-scroll_pos`. No modulo operator.
  - `bg_addr = (hor-BG_X) + row*BG_W`.
- **Stage B.** Hit flags and `bg_on` are delayed 1 clk to align with ROM data.
- **Stage C (registered).**
  - A sprite is opaque when it hits and `spr_data[i] != KEY`.
  - `pixel_rgb` is the lowest-index opaque sprite colour, else `bg_data` if `bg_on`, else 0.
- **Frame detect.** `frame_end` is a one-clk pulse on the rising edge of `(hor==H_LAST && ver==V_LAST)`.
- **Scroll counter.**
  - On `frame_end` with `scroll_en`, the frame counter counts 0..FRAME_DIV-1.
  - At terminal count, `scroll_pos` increments, wrapping BG_H-1 → 0, and `scroll_tick` pulses.
  - With `scroll_en`=0, both counters hold.
- **Collision.**
  - `collision` sets when two or more sprites are opaque on the same Stage C pixel.
  - It stays set until `collision_clr`.
  - If clear and set occur in the same clk, set wins.

## Timing
- Latency from `hor_pix`/`ver_pix` to `pixel_rgb` is 3 clk. The caller compensates with its sync delay.
- ROMs must be synchronous with exactly 1-clk read latency.
- Reset values:
  - `pixel_rgb`, `spr_addr`, `bg_addr`: 0.
  - `scroll_pos`, frame counter: 0.
  - `scroll_tick`, `collision`: 0.
  - Pipeline valid flags: 0.
- Reset asserted mid-frame clears everything immediately. Output is black until 3 clk after release.
- Position inputs are sampled every clk. The game logic updates them only on `scroll_tick`, to avoid mid-frame tearing; the block does not enforce this.
- `scroll_tick` is asserted in the clk after `frame_end`.

## Configuration
- `SPRITE_COLLISION_EN`:
  - Defined: collision logic is built as described.
  - Undefined: `collision` is tied to 0, `collision_clr` is ignored, and no overlap logic is synthesised.

## Test plan
- **Priority.** Sprite 0 at (270,300) and sprite 1 at (276,300), both opaque red/blue ROMs. At pixel (278,305), `pixel_rgb` equals the sprite 0 colour 3 clk later.
- **Transparency.** Sprite 0 texel = 12'hA0A at (270,300), inside the background. `pixel_rgb` equals `bg_data` for that address.
- **Scroll wrap.** `scroll_en`=1 with FRAME_DIV=5 for 5*240 frames. `scroll_tick` pulses 240 times and `scroll_pos` goes 239 → 0. At `scroll_pos`=10, pixel (200,150) reads `bg_addr`=230*160=36800.
- **Freeze.** `scroll_en`=0 for 20 frames: `scroll_pos` is unchanged and there are no ticks.
- **Collision.** Two opaque sprites overlap at one pixel: `collision` rises and stays 1. With `collision_clr` pulsed and sprites disjoint, it is 0 next clk. With `SPRITE_COLLISION_EN` undefined, it stays 0.
- **Edge and reset.** Sprite at x=2^WIDTH-4: there are no hits at hor 0..9. Reset during an active line gives all outputs 0 and restart with `scroll_pos`=0.
